// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer between fetch and decode.
// Define IFID_STALL_COUNT_EN to add the stall_cnt decode-stall counter output.
module if_id_pipe_reg #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [1:0]         occupancy
`ifdef IFID_STALL_COUNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    // Handshake: a beat moves on a side only in a cycle where that side's valid
    // and ready are both high; ready/valid here come from registers only.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  main_pc;
    logic [INSTR_W-1:0] main_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               main_vld;
    logic               skid_vld;
    logic               acc;
    logic               pop;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid_in;

    assign main_vld  = (state != EMPTY);
    assign skid_vld  = (state == FULL);
    assign occupancy = state;
    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_pc    = main_pc;
    assign out_instr = main_vld ? main_instr : '0;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            // Taken branch: drop everything held, including this cycle's offer.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        load_main_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        load_skid_in = 1'b1;
                        state_nxt    = FULL;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_pc    <= in_pc;
                main_instr <= in_instr;
            end else if (load_main_skid) begin
                main_pc    <= skid_pc;
                main_instr <= skid_instr;
            end
            if (load_skid_in) begin
                skid_pc    <= in_pc;
                skid_instr <= in_instr;
            end
        end
    end

`ifdef IFID_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
